// File: rtl/rr_arbiter_4to1.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4to1
//   Round-robin arbiter for four level-sensitive requesters producing a
//   registered one-hot grant on d0..d3. A winner keeps the grant until it
//   signals done, drops its request, or exceeds MAX_HOLD grant cycles (forced
//   release, flagged by a one-cycle timeout pulse). Every release passes
//   through at least one all-zero IDLE cycle, so the grant lines are always
//   all-zero or one-hot and can feed the 4-to-2 encoder directly.
//
//   Optional feature macro: RR_GRANT_CNT_EN
//     When defined, adds CNT_W and the gnt_cnt output: one saturating counter
//     per requester counting IDLE->GRANT entries won by that requester.
// -----------------------------------------------------------------------------
module rr_arbiter_4to1 #(
   parameter int MAX_HOLD = 8
`ifdef RR_GRANT_CNT_EN
   ,
   parameter int CNT_W = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic req2,
   input  logic req3,
   input  logic done,
   output logic d0,
   output logic d1,
   output logic d2,
   output logic d3,
   output logic busy,
   output logic timeout
`ifdef RR_GRANT_CNT_EN
   ,
   output logic [4*CNT_W-1:0] gnt_cnt
`endif
);

   // Hold counter only has to reach MAX_HOLD; keep at least one bit so the
   // timeout-disabled build still elaborates cleanly.
   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_MAXV  = {HOLD_W{1'b1}};

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state;
   logic [1:0]          ptr;        // highest-priority requester for next arbitration
   logic [1:0]          owner;      // current grant holder (valid in GRANT)
   logic [HOLD_W-1:0]   hold;       // grant cycles elapsed, 1 in the first grant cycle
   logic [3:0]          gnt;        // registered one-hot grant
   logic [3:0]          req_vec;
   logic [2:0]          pick;       // {found, index} of the round-robin winner
   logic                owner_req;
   logic                hold_expired;
   logic                release_now;

   // First asserted request scanning ptr, ptr+1, ... (mod 4). Scanning the
   // offsets from farthest to nearest lets the nearest match overwrite.
   function automatic logic [2:0] pick_winner(input logic [3:0] r,
                                              input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Saturating increment of the hold counter; only matters when the timeout
   // is disabled and a grant can outlast the counter range.
   function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
      return (h == HOLD_MAXV) ? h : h + HOLD_W'(1);
   endfunction

   assign req_vec = {req3, req2, req1, req0};

   // Winner selection and release conditions for the current cycle
   always_comb begin
      pick         = pick_winner(req_vec, ptr);
      owner_req    = req_vec[owner];
      hold_expired = (MAX_HOLD != 0) && (hold == HOLD_LIMIT);
      release_now  = done || !owner_req || hold_expired;
   end

   // Arbiter FSM: IDLE picks a winner, GRANT holds it until a release cause
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= 4'b0000;
         busy    <= 1'b0;
         timeout <= 1'b0;
         ptr     <= 2'd0;
         owner   <= 2'd0;
         hold    <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick[2]) begin
                  state <= GRANT;
                  owner <= pick[1:0];
                  gnt   <= 4'b0001 << pick[1:0];
                  busy  <= 1'b1;
                  hold  <= HOLD_W'(1);
               end
            end
            GRANT: begin
               if (release_now) begin
                  state   <= IDLE;
                  gnt     <= 4'b0000;
                  busy    <= 1'b0;
                  hold    <= '0;
                  ptr     <= owner + 2'd1;
                  // Forced release is reported only when nothing else would
                  // have released the grant at this edge anyway.
                  timeout <= hold_expired && !done && owner_req;
               end else begin
                  hold <= hold_inc(hold);
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 4'b0000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign d0 = gnt[0];
   assign d1 = gnt[1];
   assign d2 = gnt[2];
   assign d3 = gnt[3];

`ifdef RR_GRANT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAXV = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt [4];

   // Saturating per-requester grant counter increment
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAXV) ? c : c + CNT_W'(1);
   endfunction

   // Count IDLE->GRANT entries per winner
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else if (state == IDLE && pick[2]) begin
         cnt[pick[1:0]] <= cnt_inc(cnt[pick[1:0]]);
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_out
      assign gnt_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
   end
`else
   // Grant statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_rr_arbiter_4to1.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4to1
//   Scoreboard bench: the stimulus process runs a behavioural model at every
//   clock edge and queues the expected outputs; a monitor process pops and
//   compares on each falling edge. Directed scenarios are followed by random
//   traffic. Honours RR_GRANT_CNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4to1;

   localparam int MAX_HOLD = 8;
   localparam int CNT_W    = 2;

   typedef struct packed {
      logic [3:0]         d;
      logic               busy;
      logic               to;
      logic [4*CNT_W-1:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic       d0, d1, d2, d3, busy, timeout;
   logic [3:0] dvec;
`ifdef RR_GRANT_CNT_EN
   logic [4*CNT_W-1:0] gnt_cnt;
`endif

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: who owns the grant (-1 = none), how long it has
   // held it, who has priority next, pending timeout flag, grant tallies.
   int   m_owner = -1;
   int   m_held  = 0;
   int   m_ptr   = 0;
   bit   m_to    = 1'b0;
   int   m_cnt[4] = '{0, 0, 0, 0};

   always #5 clk = ~clk;

   assign dvec = {d3, d2, d1, d0};

   rr_arbiter_4to1 #(
      .MAX_HOLD(MAX_HOLD)
`ifdef RR_GRANT_CNT_EN
      ,
      .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .req0(req[0]),
      .req1(req[1]),
      .req2(req[2]),
      .req3(req[3]),
      .done(done),
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .d3(d3),
      .busy(busy),
      .timeout(timeout)
`ifdef RR_GRANT_CNT_EN
      ,
      .gnt_cnt(gnt_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] actual,
                      input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Apply the arbitration rules to the inputs present at this edge.
   task automatic model_edge();
      bit expire;
      if (rst) begin
         m_owner = -1;
         m_held  = 0;
         m_ptr   = 0;
         m_to    = 1'b0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (req[idx]) begin
               m_owner = idx;
               m_held  = 1;
               if (m_cnt[idx] < (1 << CNT_W) - 1) m_cnt[idx]++;
               break;
            end
         end
      end else begin
         expire = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
         if (done || !req[m_owner] || expire) begin
            m_to    = expire && !done && req[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_held  = 0;
         end else begin
            m_held++;
            m_to = 1'b0;
         end
      end
   endtask

   // One clock: update the model at the edge, queue expectation, then move
   // past the edge so callers can drive the next inputs.
   task automatic step();
      exp_t e;
      @(posedge clk);
      model_edge();
      e.d    = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.busy = (m_owner >= 0);
      e.to   = m_to;
      for (int i = 0; i < 4; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: compare each registered output set against the scoreboard
   initial begin
      exp_t        e;
      logic [1:0]  enc;
      logic [3:0]  g;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", {dvec, busy, timeout}, {e.d, e.busy, e.to});
            chk("onehot", ($countones(dvec) <= 1), 1);
            if (dvec != 4'b0000) begin
               enc = {dvec[3] | dvec[2], dvec[3] | dvec[1]};
               g   = 4'b0001 << enc;
               chk("enc_dec_chain", g, dvec);
            end
`ifdef RR_GRANT_CNT_EN
            chk("gnt_cnt", gnt_cnt, e.cnt);
`endif
         end
      end
   end

   // Stimulus
   initial begin
      int d2_cycles;
      int to_pulses;
      int exp_idx;

      rst = 1'b1; req = 4'b0000; done = 1'b0;
      step(); step();
      chk("reset_state", {dvec, busy, timeout}, 6'b0);
      rst = 1'b0;

      // Basic grant, done release, pointer advance
      req = 4'b0001; step();
      chk("t1_grant_d0", {dvec, busy}, 5'b00011);
      done = 1'b1; step();
      chk("t1_release", dvec, 4'b0000);
      done = 1'b0; req = 4'b0011; step();
      chk("t1_ptr_d1", dvec, 4'b0010);
      req = 4'b0000; step(); step();

      // Rotation with all requesting and done every grant cycle
      rst = 1'b1; step(); rst = 1'b0;
      req = 4'b1111; done = 1'b1; exp_idx = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (dvec != 4'b0000) begin
            chk("t2_order", dvec, 4'b0001 << exp_idx);
            exp_idx = (exp_idx + 1) % 4;
         end
      end
      chk("t2_grants", exp_idx, 1);
      req = 4'b0000; done = 1'b0; step(); step();

      // Forced release after MAX_HOLD cycles
      req = 4'b0100; d2_cycles = 0; to_pulses = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (d2) d2_cycles++;
         if (timeout) to_pulses++;
      end
      chk("t3_hold_len", d2_cycles, MAX_HOLD);
      chk("t3_timeout", to_pulses, 1);
      step();
      chk("t3_regrant", dvec, 4'b0100);
      req = 4'b0000; step(); step();

      // done in the last hold cycle: normal release
      req = 4'b0001;
      for (int i = 0; i < MAX_HOLD; i++) step();
      done = 1'b1; step();
      chk("t4_done_no_to", {dvec, timeout}, 5'b0);
      done = 1'b0; req = 4'b0000; step();
      // request drop in the last hold cycle: normal release
      req = 4'b0001;
      for (int i = 0; i < MAX_HOLD; i++) step();
      req = 4'b0000; step();
      chk("t4_drop_no_to", {dvec, timeout}, 5'b0);
      step();

      // Reset in the middle of a d3 grant
      req = 4'b1000; step(); step(); step();
      rst = 1'b1; step();
      chk("t5_reset_drop", {dvec, busy, timeout}, 6'b0);
      rst = 1'b0; req = 4'b1010; step();
      chk("t5_ptr_restart", dvec, 4'b0010);
      req = 4'b0000; step(); step();

      // Repeated grants to requester 0 (counter saturation when enabled)
      rst = 1'b1; step(); rst = 1'b0;
      req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step();
         done = 1'b1; step();
         done = 1'b0;
      end
`ifdef RR_GRANT_CNT_EN
      chk("t6_cnt_sat", gnt_cnt, (4*CNT_W)'(3));
`endif
      req = 4'b0000; step();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 9) == 0);
         rst  = ($urandom_range(0, 149) == 0);
         step();
      end

      rst = 1'b0; req = 4'b0000; done = 1'b0;
      step();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
